// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between two writeback requesters
//
// Requester A (ALU) and B (load) each feed a DEPTH-entry FIFO. A round-robin
// arbiter drains one head per cycle into a registered write stage, and the
// pending entries are compared against the decode read addresses to raise hazards.
//
// Ports:
//   clk                          rising-edge clock
//   rst                          asynchronous reset, active-low
//   a_valid/a_ready/a_addr/a_data  requester A write handshake
//   b_valid/b_ready/b_addr/b_data  requester B write handshake
//   wr_en/wr_addr/wr_data        regfile write port
//   chk_addr1/chk_addr2          decode read addresses
//   hazard1/hazard2              read address has a pending write
//   idle                         nothing queued and no write in flight
//   fwd1_valid/fwd1_data,
//   fwd2_valid/fwd2_data         unique pending match and its data
//                                (only when REGFILE_WB_FWD_EN is defined)
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              idle
`ifdef REGFILE_WB_FWD_EN
    ,
    output logic              fwd1_valid,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_valid,
    output logic [DATA_W-1:0] fwd2_data
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NC = 2 * DEPTH + 1;

    logic [ADDR_W-1:0] a_am [DEPTH];
    logic [DATA_W-1:0] a_dm [DEPTH];
    logic [ADDR_W-1:0] b_am [DEPTH];
    logic [DATA_W-1:0] b_dm [DEPTH];
    logic [PW-1:0]     a_wp, a_rp, b_wp, b_rp;
    logic [CW-1:0]     a_cnt, b_cnt;
    logic              rr_a;
    logic              a_push, b_push, a_pop, b_pop;

    logic              cv [NC];
    logic [ADDR_W-1:0] ca [NC];
`ifdef REGFILE_WB_FWD_EN
    logic [DATA_W-1:0] cd [NC];
`endif

    assign a_ready = a_cnt != CW'(DEPTH);
    assign b_ready = b_cnt != CW'(DEPTH);
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;
    // rr_a set means A wins a tie; a lone non-empty FIFO always wins
    assign a_pop   = (a_cnt != '0) && (rr_a || b_cnt == '0);
    assign b_pop   = (b_cnt != '0) && !a_pop;
    assign idle    = (a_cnt == '0) && (b_cnt == '0) && !wr_en;

    // Storage needs no reset: only entries below the count are ever observed
    always_ff @(posedge clk) begin
        if (a_push) begin
            a_am[a_wp] <= a_addr;
            a_dm[a_wp] <= a_data;
        end
        if (b_push) begin
            b_am[b_wp] <= b_addr;
            b_dm[b_wp] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_wp    <= '0;
            a_rp    <= '0;
            a_cnt   <= '0;
            b_wp    <= '0;
            b_rp    <= '0;
            b_cnt   <= '0;
            rr_a    <= 1'b1;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            a_wp  <= a_wp + PW'(a_push);
            a_rp  <= a_rp + PW'(a_pop);
            a_cnt <= a_cnt + CW'(a_push) - CW'(a_pop);
            b_wp  <= b_wp + PW'(b_push);
            b_rp  <= b_rp + PW'(b_pop);
            b_cnt <= b_cnt + CW'(b_push) - CW'(b_pop);
            if (a_pop)
                rr_a <= 1'b0;
            else if (b_pop)
                rr_a <= 1'b1;
            wr_en <= a_pop || b_pop;
            if (a_pop) begin
                wr_addr <= a_am[a_rp];
                wr_data <= a_dm[a_rp];
            end else if (b_pop) begin
                wr_addr <= b_am[b_rp];
                wr_data <= b_dm[b_rp];
            end
        end
    end

    // Flatten every pending entry (both FIFOs plus the write stage) into one list
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            cv[k]         = CW'(k) < a_cnt;
            ca[k]         = a_am[a_rp + PW'(k)];
            cv[k + DEPTH] = CW'(k) < b_cnt;
            ca[k + DEPTH] = b_am[b_rp + PW'(k)];
`ifdef REGFILE_WB_FWD_EN
            cd[k]         = a_dm[a_rp + PW'(k)];
            cd[k + DEPTH] = b_dm[b_rp + PW'(k)];
`endif
        end
        cv[NC-1] = wr_en;
        ca[NC-1] = wr_addr;
`ifdef REGFILE_WB_FWD_EN
        cd[NC-1] = wr_data;
`endif
    end

    // A forward is valid on the first match and withdrawn by any further match
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
`ifdef REGFILE_WB_FWD_EN
        fwd1_valid = 1'b0;
        fwd1_data  = '0;
        fwd2_valid = 1'b0;
        fwd2_data  = '0;
`endif
        for (int k = 0; k < NC; k++) begin
            if (cv[k] && ca[k] == chk_addr1) begin
`ifdef REGFILE_WB_FWD_EN
                fwd1_valid = !hazard1;
                fwd1_data  = cd[k];
`endif
                hazard1 = 1'b1;
            end
            if (cv[k] && ca[k] == chk_addr2) begin
`ifdef REGFILE_WB_FWD_EN
                fwd2_valid = !hazard2;
                fwd2_data  = cd[k];
`endif
                hazard2 = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter
// Requester B data always carries bit 31 set so each write can be routed
// back to the queue of the requester that produced it.
module tb_regfile_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] chk_addr1 = '0;
    logic [AW-1:0] chk_addr2 = '0;
    logic          hazard1, hazard2, idle;
`ifdef REGFILE_WB_FWD_EN
    logic          fwd1_valid, fwd2_valid;
    logic [DW-1:0] fwd1_data, fwd2_data;
`endif

    logic [AW+DW-1:0] txa[$], txb[$], qa[$], qb[$];
    logic [AW+DW-1:0] e;
    bit               sides[$];
    int               wcyc[$];
    int               checks = 0, errors = 0, cyc = 0, nwr = 0;

    regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .hazard1(hazard1), .hazard2(hazard2), .idle(idle)
`ifdef REGFILE_WB_FWD_EN
        , .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

    // Drivers: present the head of each transmit queue just after every rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (txa.size() > 0) begin
            a_valid = 1'b1;
            {a_addr, a_data} = txa[0];
        end else a_valid = 1'b0;
        if (txb.size() > 0) begin
            b_valid = 1'b1;
            {b_addr, b_data} = txb[0];
        end else b_valid = 1'b0;
    end

    // Monitor: record accepts into the scoreboard and check every write against it
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (a_valid && a_ready && txa.size() > 0) qa.push_back(txa.pop_front());
            if (b_valid && b_ready && txb.size() > 0) qb.push_back(txb.pop_front());
            if (wr_en) begin
                nwr++;
                sides.push_back(wr_data[DW-1]);
                wcyc.push_back(cyc);
                checks++;
                if (wr_data[DW-1] ? qb.size() == 0 : qa.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
                end else begin
                    e = wr_data[DW-1] ? qb.pop_front() : qa.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        errors++;
                        $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                                 wr_addr, wr_data, e[AW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset;
        rst = 1'b0;
        txa.delete(); txb.delete(); qa.delete(); qb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (idle && txa.size() == 0 && txb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, required 0", wr_en); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d, required 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h, required 0", wr_data); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b, required 1", idle); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b, required 1", a_ready); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got %b, required 1", b_ready); end
        rst = 1'b1;
    endtask

    task automatic test_single;
        txa.push_back({5'd3, 32'h11});
        repeat (2) @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_early_write: got wr_en=%b, required 0", wr_en); end
        @(negedge clk);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b, required 1", wr_en); end
        checks++; if (wr_addr !== 5'd3) begin errors++; $display("FAIL single_wr_addr: got %0d, required 3", wr_addr); end
        checks++; if (wr_data !== 32'h11) begin errors++; $display("FAIL single_wr_data: got %h, required 11", wr_data); end
        @(negedge clk);
        checks++; if (idle !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL single_idle: got idle=%b wr_en=%b, required 1 0", idle, wr_en); end
    endtask

    task automatic test_hazard;
        logic [3:0] h = 4'b0110;
        chk_addr1 = 5'd7;
        chk_addr2 = 5'd8;
        txa.push_back({5'd7, 32'h77});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (hazard1 !== h[c]) begin errors++; $display("FAIL hazard1_c%0d: got %b, required %b", c + 1, hazard1, h[c]); end
            checks++; if (hazard2 !== 1'b0) begin errors++; $display("FAIL hazard2_c%0d: got %b, required 0", c + 1, hazard2); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int n = 0;
        do_reset();
        sides.delete();
        wcyc.delete();
        for (int i = 0; i < 8; i++) begin
            txa.push_back({5'(i + 1), 32'h100 + 32'(i)});
            txb.push_back({5'(i + 10), 32'h8000_0200 + 32'(i)});
        end
        while ((txa.size() > 0 || txb.size() > 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n > 16) begin errors++; $display("FAIL b2b_accept_rate: got %0d cycles, required <= 16", n); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got busy, required idle within 100 cycles"); end
        checks++; if (sides.size() != 16) begin errors++; $display("FAIL b2b_write_count: got %0d, required 16", sides.size()); end
        for (int i = 0; i < sides.size(); i++) begin
            checks++;
            if (sides[i] != bit'(i % 2)) begin errors++; $display("FAIL b2b_grant_%0d: got side %0d, required %0d", i, sides[i], i % 2); end
        end
        if (wcyc.size() == 16) begin
            checks++;
            if (wcyc[15] - wcyc[0] != 15) begin errors++; $display("FAIL b2b_gapless: got span %0d, required 15", wcyc[15] - wcyc[0]); end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [3:0] br = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) txa.push_back({5'(i + 20), 32'h300 + 32'(i)});
        for (int i = 0; i < 3; i++) txb.push_back({5'(i + 25), 32'h8000_0400 + 32'(i)});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (b_ready !== br[c]) begin errors++; $display("FAIL bp_b_ready_c%0d: got %b, required %b", c + 1, b_ready, br[c]); end
        end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got busy, required idle within 100 cycles"); end
        checks++; if (qa.size() + qb.size() != 0) begin errors++; $display("FAIL bp_leftover: got %0d unwritten, required 0", qa.size() + qb.size()); end
    endtask

    task automatic test_mid_reset;
        int n0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            txa.push_back({5'(i + 1), 32'h500 + 32'(i)});
            txb.push_back({5'(i + 5), 32'h8000_0600 + 32'(i)});
        end
        repeat (3) @(negedge clk);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL mr_pre_write: got wr_en=%b, required 1", wr_en); end
        rst = 1'b0;
        txa.delete(); txb.delete(); qa.delete(); qb.delete();
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mr_wr_en: got %b, required 0", wr_en); end
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got a=%b b=%b, required 1 1", a_ready, b_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mr_idle: got %b, required 1", idle); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n0 = nwr;
        repeat (6) @(negedge clk);
        checks++; if (nwr != n0) begin errors++; $display("FAIL mr_no_writes: got %0d writes, required 0", nwr - n0); end
    endtask

`ifdef REGFILE_WB_FWD_EN
    task automatic test_fwd;
        bit ok;
        do_reset();
        chk_addr1 = 5'd5;
        chk_addr2 = 5'd9;
        txa.push_back({5'd5, 32'hABCD});
        @(negedge clk);
        txb.push_back({5'd5, 32'h8000_5555});
        @(negedge clk);
        checks++; if (fwd1_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b, required 1", fwd1_valid); end
        checks++; if (fwd1_data !== 32'hABCD) begin errors++; $display("FAIL fwd_data: got %h, required abcd", fwd1_data); end
        checks++; if (fwd2_valid !== 1'b0) begin errors++; $display("FAIL fwd2_valid: got %b, required 0", fwd2_valid); end
        @(negedge clk);
        checks++; if (fwd1_valid !== 1'b0) begin errors++; $display("FAIL fwd_multi_valid: got %b, required 0", fwd1_valid); end
        checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL fwd_multi_hazard: got %b, required 1", hazard1); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fwd_drain: got busy, required idle within 100 cycles"); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_hazard();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
`ifdef REGFILE_WB_FWD_EN
        test_fwd();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU/execute) and B (load/memory).
- Each requester has a DEPTH-entry FIFO; a round-robin arbiter drains one entry per cycle into a registered write stage that drives the regfile write/waddr1/din inputs.
- Reports pending-write hazards to the decode-stage read ports so the pipeline stalls instead of reading stale data.

Parameters:
ADDR_W, 5, register address width (matches RegAddrBus)
DATA_W, 32, register data width (matches RegBus)
DEPTH, 2, entries per requester FIFO (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
a_valid  in  1  requester A write request
a_ready  out  1  requester A FIFO can accept
a_addr  in  ADDR_W  requester A destination register
a_data  in  DATA_W  requester A write data
b_valid  in  1  requester B write request
b_ready  out  1  requester B FIFO can accept
b_addr  in  ADDR_W  requester B destination register
b_data  in  DATA_W  requester B write data
wr_en  out  1  regfile write enable
wr_addr  out  ADDR_W  regfile write address
wr_data  out  DATA_W  regfile write data
chk_addr1  in  ADDR_W  decode read address 1
chk_addr2  in  ADDR_W  decode read address 2
hazard1  out  1  chk_addr1 has a pending write
hazard2  out  1  chk_addr2 has a pending write
idle  out  1  both FIFOs empty and write stage empty

Behaviour:
- Reset (rst=0, async): FIFOs emptied, pointers/counts 0, rr pointer = A. wr_en=0, wr_addr=0, wr_data=0, idle=1, a_ready=b_ready=1. Reset mid-operation discards all queued entries; no write issues after reset asserts.
- Enqueue: the entry is accepted on the clk edge where x_valid && x_ready. x_ready = (count_x != DEPTH), combinational from state only and never from x_valid. Data/addr are captured at the accept edge.
- Arbitration each cycle over FIFO heads:
  - Only one non-empty: grant it.
  - Both non-empty: grant the side opposite the last grant (round-robin). After granting, the rr pointer points to the other side.
  - Neither non-empty: no grant; wr_en=0 next cycle.
- Write stage: registered. A grant at cycle N pops the head at edge N and drives wr_en=1 with that addr/data during cycle N+1.
  - Minimum latency from accept edge to wr_en high is 2 cycles. An entry is not granted in its accept cycle.
  - Throughput is 1 write/cycle sustained.
- Full/empty: pop and push on the same FIFO in the same cycle are legal. Count is unchanged, so a full FIFO that pops this cycle keeps x_ready=0 this cycle; ready rises next cycle.
- Pointers wrap modulo DEPTH.
- Hazard: hazard1=1 if chk_addr1 equals the addr of any valid entry in either FIFO or the write stage while wr_en=1. hazard2 is the same for chk_addr2. The check is combinational. Address 0 is treated like any other register.
- Cross-requester ordering to the same address is not enforced. Upstream must not issue a second write to an address while its hazard is high.
- idle = (count_a==0) && (count_b==0) && !wr_en.
- An enqueue accepted the same cycle as a hazard check is not visible until the next cycle.

Optional Feature:
REGFILE_WB_FWD_EN
- With the macro: adds outputs fwd1_valid, fwd1_data, fwd2_valid and fwd2_data.
  - fwdN_valid=1 when the hazardN match is unique among pending entries; fwdN_data is that entry's data.
  - With multiple matches, fwdN_valid=0 and hazardN stays 1.
  - Decode may use forwarded data instead of stalling.
- Without the macro: these ports and their compare logic do not exist; the hazard outputs are unchanged.

Test Plan:
- Reset release, single A push (addr=3, data=0x11) at cycle 1 -> wr_en=1, wr_addr=3, wr_data=0x11 at cycle 3; idle=1 at cycle 4.
- A and B push every cycle for 8 cycles -> wr_en stays high, grants alternate A,B,A,B with A first after reset; neither ready drops below sustained rate.
- B pushes 3 entries with no drain blocked (A saturating, DEPTH=2) -> b_ready=0 after 2 queued; the third is accepted only the cycle after a B pop.
- A push addr=7, chk_addr1=7 -> hazard1=1 from the cycle after accept through the wr_en cycle, 0 the cycle after; chk_addr2=8 -> hazard2=0 throughout.
- Fill both FIFOs, assert rst=0 mid-stream -> wr_en=0 immediately, a_ready=b_ready=1, idle=1; no further writes after release.
- With REGFILE_WB_FWD_EN, A push addr=5, data=0xABCD, chk_addr1=5 -> fwd1_valid=1, fwd1_data=0xABCD. Then a B push to addr 5 is accepted -> fwd1_valid=0, hazard1=1.
